// File: rtl/execute_muldiv_unit.sv
// ----------------------------------------------------------------------------
// execute_muldiv_unit
//
// Iterative multiply/divide unit for the Execute stage. It computes one
// multiplier bit (shift-add) or one quotient bit (restoring divide) per
// cycle on operand magnitudes, then spends one FIX cycle on sign correction
// and the architectural HI/LO write.
//
// Ports
//   CLK       : clock, all state updates on the rising edge
//   RST       : asynchronous active-high reset
//   StartE    : start request (sampled on CLK edge, honoured only in IDLE)
//   OpE[1:0]  : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   SrcAE     : multiplicand / dividend
//   SrcBE     : multiplier / divisor
//   AbortE    : flush; cancels an in-flight operation or a same-cycle start
//   BusyE     : high while state != IDLE (stall request to the hazard unit)
//   DoneE     : registered one-cycle pulse in the cycle after the HI/LO write
//   HI, LO    : product high/low halves, or remainder/quotient
//   DivZeroE  : sticky flag, last completed divide had a zero divisor
//   dbg_state : raw FSM state register for observation
//
// Handshake: a request is taken when StartE=1, AbortE=0 and BusyE=0 at a
// rising edge; StartE while BusyE=1 is dropped, not queued. The result is
// presented by DoneE=1 for exactly one cycle with HI/LO already holding it,
// and the unit is ready for a new StartE in that same cycle.
// ----------------------------------------------------------------------------
module execute_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             AbortE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivZeroE,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero_q;
    // Shared datapath register. MUL: {partial product, remaining multiplier}.
    // DIV: {partial remainder, dividend bits shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc;

    // Magnitudes of the incoming operands (signed ops only).
    logic [WIDTH-1:0]   src_a_mag;
    logic [WIDTH-1:0]   src_b_mag;
    // Magnitudes of the latched operands; the sign bits are only ever set for
    // signed ops, so unsigned operands pass straight through.
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign BusyE     = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        src_a_mag = (OpE[0] && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        src_b_mag = (OpE[0] && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
        a_mag     = sign_a ? -a_q : a_q;
        b_mag     = sign_b ? -b_q : b_q;
    end

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole accumulator right
    // with the carry-out entering at the top, so nothing is truncated.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Restoring step: bring down the next dividend bit, subtract the divisor
    // if it fits, and shift the resulting quotient bit in at the bottom.
    // The partial remainder is always below the divisor, so the kept value
    // fits in WIDTH bits in both branches.
    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_ge    = (div_shift >= {1'b0, b_mag});
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    // Sign correction. Most-negative / -1 needs no special case: the
    // magnitude quotient 2^(WIDTH-1) negates to itself modulo 2^WIDTH.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (op_q[1]) begin
            if (div_zero_q) begin
                fix_hi = a_q;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div_zero_q <= 1'b0;
            acc        <= '0;
            HI         <= '0;
            LO         <= '0;
            DivZeroE   <= 1'b0;
            DoneE      <= 1'b0;
        end else begin
            DoneE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (StartE && !AbortE) begin
                        op_q   <= OpE;
                        a_q    <= SrcAE;
                        b_q    <= SrcBE;
                        sign_a <= OpE[0] & SrcAE[WIDTH-1];
                        sign_b <= OpE[0] & SrcBE[WIDTH-1];
                        cnt    <= '0;
                        if (OpE[1]) begin
                            acc <= {{WIDTH{1'b0}}, src_a_mag};
                            if (SrcBE == '0) begin
                                div_zero_q <= 1'b1;
                                state      <= S_FIX;
                            end else begin
                                div_zero_q <= 1'b0;
                                state      <= S_DIV;
                            end
                        end else begin
                            acc        <= {{WIDTH{1'b0}}, src_b_mag};
                            div_zero_q <= 1'b0;
                            state      <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (AbortE) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (AbortE) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!AbortE) begin
                        HI    <= fix_hi;
                        LO    <= fix_lo;
                        DoneE <= 1'b1;
                        if (op_q[1]) DivZeroE <= div_zero_q;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_execute_muldiv_unit
//
// Directed and random stimulus for execute_muldiv_unit at WIDTH=32. Expected
// results come from a behavioural model using native wide arithmetic and are
// queued at start time, then popped when DoneE is observed.
// ----------------------------------------------------------------------------
module tb_execute_muldiv_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         StartE = 1'b0;
    logic [1:0]   OpE = 2'b00;
    logic [W-1:0] SrcAE = '0;
    logic [W-1:0] SrcBE = '0;
    logic         AbortE = 1'b0;
    logic         BusyE;
    logic         DoneE;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         DivZeroE;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {DivZeroE, HI, LO}
    logic [2*W:0] exp_q[$];
    logic         model_dz = 1'b0;
    logic [W-1:0] last_hi  = '0;
    logic [W-1:0] last_lo  = '0;

    execute_muldiv_unit #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .StartE    (StartE),
        .OpE       (OpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .AbortE    (AbortE),
        .BusyE     (BusyE),
        .DoneE     (DoneE),
        .HI        (HI),
        .LO        (LO),
        .DivZeroE  (DivZeroE),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------ clock
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------ model
    function automatic logic [2*W:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic dz_in);
        logic [2*W-1:0] p;
        logic [W-1:0]   hi;
        logic [W-1:0]   lo;
        logic           dz;
        int             sa;
        int             sb;
        dz = dz_in;
        hi = '0;
        lo = '0;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                hi = p[2*W-1:W];
                lo = p[W-1:0];
            end
            2'b01: begin
                p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                hi = p[2*W-1:W];
                lo = p[W-1:0];
            end
            2'b10: begin
                if (b == '0) begin
                    hi = a; lo = '1; dz = 1'b1;
                end else begin
                    hi = a % b; lo = a / b; dz = 1'b0;
                end
            end
            default: begin
                if (b == '0) begin
                    hi = a; lo = '1; dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = '0; lo = a; dz = 1'b0;
                end else begin
                    hi = sa % sb; lo = sa / sb; dz = 1'b0;
                end
            end
        endcase
        return {dz, hi, lo};
    endfunction

    // ---------------------------------------------------------------- drivers
    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit push);
        logic [2*W:0] e;
        StartE = 1'b1;
        OpE    = op;
        SrcAE  = a;
        SrcBE  = b;
        if (push) begin
            e = model(op, a, b, model_dz);
            model_dz = e[2*W];
            exp_q.push_back(e);
        end
    endtask

    // Waits for DoneE after a start_op, counting falling edges from the first
    // cycle after the start edge. Optionally pulses a bogus StartE mid-flight.
    task automatic wait_done(input int exp_lat, input int inject_cyc,
                             input string name);
        int           cyc;
        int           busy_cnt;
        int           hold_err;
        logic [2*W:0] e;
        @(negedge CLK);
        StartE   = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        hold_err = 0;
        while (DoneE !== 1'b1 && cyc < 200) begin
            if (BusyE === 1'b1) busy_cnt++;
            if (HI !== last_hi || LO !== last_lo) hold_err++;
            if (cyc == inject_cyc) begin
                StartE = 1'b1; OpE = 2'b00; SrcAE = 32'h0000_1234; SrcBE = 32'h5;
            end else begin
                StartE = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        StartE = 1'b0;
        checks++;
        if (DoneE !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: DoneE=%b after %0d cycles, required 1", name, DoneE, cyc);
        end
        checks++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, cyc, exp_lat);
        end
        checks++;
        if (busy_cnt !== exp_lat - 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, exp_lat - 1);
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL %s hilo_hold: %0d cycles changed before DoneE, required 0", name, hold_err);
        end
        checks++;
        if (BusyE !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b, required 0", name, BusyE);
        end
        e = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
        checks++;
        if (HI !== e[2*W-1:W]) begin
            errors++;
            $display("FAIL %s hi: got %h, required %h", name, HI, e[2*W-1:W]);
        end
        checks++;
        if (LO !== e[W-1:0]) begin
            errors++;
            $display("FAIL %s lo: got %h, required %h", name, LO, e[W-1:0]);
        end
        checks++;
        if (DivZeroE !== e[2*W]) begin
            errors++;
            $display("FAIL %s divzero: got %b, required %b", name, DivZeroE, e[2*W]);
        end
        last_hi = e[2*W-1:W];
        last_lo = e[W-1:0];
    endtask

    // Watches n cycles; no DoneE, idle, and HI/LO/DivZeroE must hold.
    task automatic expect_quiet(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (DoneE !== 1'b0 || BusyE !== 1'b0 || HI !== last_hi ||
                LO !== last_lo || DivZeroE !== model_dz) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s quiet: %0d bad cycles (Done=%b Busy=%b HI=%h LO=%h DZ=%b), required 0",
                     name, bad, DoneE, BusyE, HI, LO, DivZeroE);
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        RST = 1'b0;
        #1 RST = 1'b1;
        #1;
        checks++;
        if ({BusyE, DoneE, DivZeroE} !== 3'b000 || HI !== '0 || LO !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: Busy=%b Done=%b DZ=%b HI=%h LO=%h st=%0d, required all 0",
                     BusyE, DoneE, DivZeroE, HI, LO, dbg_state);
        end
        StartE = 1'b1; OpE = 2'b00; SrcAE = 32'h7; SrcBE = 32'h9;
        repeat (2) @(negedge CLK);
        checks++;
        if ({BusyE, DoneE, DivZeroE} !== 3'b000 || HI !== '0 || LO !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_held: Busy=%b Done=%b DZ=%b HI=%h LO=%h st=%0d, required all 0",
                     BusyE, DoneE, DivZeroE, HI, LO, dbg_state);
        end
        StartE = 1'b0;
        RST = 1'b0;
        model_dz = 1'b0; last_hi = '0; last_lo = '0;
        expect_quiet(2, "after_reset");
    endtask

    task automatic test_multu_max();
        @(negedge CLK);
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(W + 2, -1, "multu_max");
        checks++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max_const: got %h_%h, required fffffffe_00000001", HI, LO);
        end
        @(negedge CLK);
        checks++;
        if (DoneE !== 1'b0 || HI !== last_hi) begin
            errors++;
            $display("FAIL done_one_cycle: DoneE=%b HI=%h, required 0 and %h", DoneE, HI, last_hi);
        end
    endtask

    task automatic test_signed();
        @(negedge CLK);
        start_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done(W + 2, -1, "mult_neg");
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg_const: got %h_%h, required ffffffff_ffffffeb", HI, LO);
        end
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(W + 2, -1, "div_neg");
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD || DivZeroE !== 1'b0) begin
            errors++;
            $display("FAIL div_neg_const: got %h_%h dz=%b, required ffffffff_fffffffd dz=0", HI, LO, DivZeroE);
        end
    endtask

    task automatic test_div_zero();
        @(negedge CLK);
        start_op(2'b10, 32'd100, 32'd0, 1'b1);
        wait_done(2, -1, "divu_zero");
        checks++;
        if (HI !== 32'd100 || LO !== 32'hFFFF_FFFF || DivZeroE !== 1'b1) begin
            errors++;
            $display("FAIL divu_zero_const: got %h_%h dz=%b, required 00000064_ffffffff dz=1", HI, LO, DivZeroE);
        end
        start_op(2'b00, 32'd2, 32'd3, 1'b1);
        wait_done(W + 2, -1, "multu_after_dz");
        checks++;
        if (HI !== 32'd0 || LO !== 32'd6 || DivZeroE !== 1'b1) begin
            errors++;
            $display("FAIL dz_sticky: got %h_%h dz=%b, required 00000000_00000006 dz=1", HI, LO, DivZeroE);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(W + 2, 5, "div_overflow");
        checks++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow_const: got %h_%h, required 00000000_80000000", HI, LO);
        end
        start_op(2'b00, 32'h10, 32'h20, 1'b1);
        wait_done(W + 2, -1, "b2b_multu");
    endtask

    task automatic test_abort();
        // Abort a DIVU mid-iteration.
        @(negedge CLK);
        start_op(2'b10, 32'd50, 32'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            StartE = 1'b0;
        end
        AbortE = 1'b1;
        @(negedge CLK);
        AbortE = 1'b0;
        checks++;
        if (BusyE !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_iter: Busy=%b st=%0d, required 0 and 0", BusyE, dbg_state);
        end
        expect_quiet(W + 4, "abort_iter");
        // Abort in the FIX cycle cancels the write.
        start_op(2'b00, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);
        for (int i = 0; i < W + 1; i++) begin
            @(negedge CLK);
            StartE = 1'b0;
        end
        checks++;
        if (dbg_state !== 2'd3) begin
            errors++;
            $display("FAIL abort_fix_state: got %0d, required 3", dbg_state);
        end
        AbortE = 1'b1;
        @(negedge CLK);
        AbortE = 1'b0;
        expect_quiet(4, "abort_fix");
        // Abort together with start in IDLE drops the start.
        start_op(2'b10, 32'd9, 32'd0, 1'b0);
        AbortE = 1'b1;
        @(negedge CLK);
        StartE = 1'b0;
        AbortE = 1'b0;
        expect_quiet(4, "abort_start");
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        start_op(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            StartE = 1'b0;
        end
        #1 RST = 1'b1;
        #1;
        checks++;
        if ({BusyE, DoneE, DivZeroE} !== 3'b000 || HI !== '0 || LO !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: Busy=%b Done=%b DZ=%b HI=%h LO=%h st=%0d, required all 0",
                     BusyE, DoneE, DivZeroE, HI, LO, dbg_state);
        end
        model_dz = 1'b0; last_hi = '0; last_lo = '0;
        @(negedge CLK);
        RST = 1'b0;
        expect_quiet(W + 4, "reset_mid_release");
        // Start driven in the same cycle RST falls is taken at the next edge.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        start_op(2'b00, 32'd7, 32'd9, 1'b1);
        wait_done(W + 2, -1, "first_after_reset");
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = (i % 4 == 1) ? 32'($urandom_range(0, 200)) : $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            start_op(op, a, b, 1'b1);
            wait_done((op[1] && b == '0) ? 2 : W + 2, -1, "random");
        end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
